// File: rtl/verify_stream_pkg.sv
// Shared types and cipher/hash helpers for the streaming verify path.
// Helpers work on a wide word and take the live width and rotate amount
// as arguments, so one package serves every W up to MAX_W.
package verify_stream_pkg;

    typedef enum logic {
        ACC = 1'b0,
        RES = 1'b1
    } state_t;

    localparam int unsigned MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    // Low w bits set.
    function automatic word_t width_mask(input int unsigned w);
        if (w >= MAX_W) return '1;
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    // Rotate left over the low w bits.
    function automatic word_t rotl(input word_t x, input int unsigned amt, input int unsigned w);
        word_t       mask;
        word_t       v;
        int unsigned a;
        mask = width_mask(w);
        v    = x & mask;
        a    = amt % w;
        if (a == 0) return v;
        return ((v << a) | (v >> (w - a))) & mask;
    endfunction

    // Rotate right over the low w bits.
    function automatic word_t rotr(input word_t x, input int unsigned amt, input int unsigned w);
        return rotl(x, w - (amt % w), w);
    endfunction

    function automatic word_t enc_byte(input word_t p, input word_t k,
                                       input int unsigned rot, input int unsigned w);
        return rotl(p ^ k, rot, w);
    endfunction

    function automatic word_t dec_byte(input word_t c, input word_t k,
                                       input int unsigned rot, input int unsigned w);
        return rotr(c, rot, w) ^ (k & width_mask(w));
    endfunction

    function automatic word_t hash_step(input word_t h, input word_t c, input int unsigned w);
        return rotl(h, 1, w) ^ (c & width_mask(w));
    endfunction

endpackage

// File: rtl/verify_stream_if.sv
// Beat input and result record bundle for verify_stream.
interface verify_stream_if #(
    parameter int unsigned W       = 8,
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(MAX_LEN);

    logic [W-1:0]  key;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_cipher;
    logic [W-1:0]  in_plain;
    logic          in_last;
    logic [W-1:0]  ref_hash;
    logic          res_valid;
    logic          res_ready;
    logic          res_pass;
    logic          res_dec_err;
    logic          res_hash_err;
    logic          res_len_err;
    logic [CW-1:0] res_bad_cnt;
    logic [IW-1:0] res_first_bad;
    logic [CW-1:0] res_len;
    logic [W-1:0]  res_hash;

    // Producer of beats and consumer of results.
    modport master (
        output key, in_valid, in_cipher, in_plain, in_last, ref_hash, res_ready,
        input  in_ready, res_valid, res_pass, res_dec_err, res_hash_err, res_len_err,
               res_bad_cnt, res_first_bad, res_len, res_hash
    );

    // The verifier itself.
    modport slave (
        input  key, in_valid, in_cipher, in_plain, in_last, ref_hash, res_ready,
        output in_ready, res_valid, res_pass, res_dec_err, res_hash_err, res_len_err,
               res_bad_cnt, res_first_bad, res_len, res_hash
    );

endinterface

// File: rtl/verify_step.sv
// One beat of verification: decrypt-and-compare plus one hash fold.
module verify_step
    import verify_stream_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned ROT = 3
) (
    input  logic [W-1:0] cipher,
    input  logic [W-1:0] plain,
    input  logic [W-1:0] key,
    input  logic [W-1:0] hash_in,
    output logic         dec_ok,
    output logic [W-1:0] hash_out
);

    logic [W-1:0] dec;

    assign dec      = W'(dec_byte(word_t'(cipher), word_t'(key), ROT, W));
    assign dec_ok   = (dec == plain);
    assign hash_out = W'(hash_step(word_t'(hash_in), word_t'(cipher), W));

endmodule

// File: rtl/verify_stream.sv
// Streaming frame verifier: accumulates per-beat checks and a keyed hash
// over a frame, then holds one result record until it is consumed.
module verify_stream
    import verify_stream_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned ROT     = 3
) (
    input logic           clk,
    input logic           rst,
    verify_stream_if.slave bus
);

    localparam int unsigned     CW      = $clog2(MAX_LEN + 1);
    localparam int unsigned     IW      = $clog2(MAX_LEN);
    localparam logic [CW-1:0]   LEN_MAX = CW'(MAX_LEN);

    state_t state, state_nxt;

    logic          accept;
    logic          res_done;
    logic          first_beat;
    logic          in_range;
    logic          dec_ok;
    logic          mismatch;
    logic [W-1:0]  beat_key;
    logic [W-1:0]  hash_in;
    logic [W-1:0]  hash_out;

    // Running accumulators for the frame in progress.
    logic [W-1:0]  key_q;
    logic [W-1:0]  hash_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] bad_q;
    logic [IW-1:0] first_bad_q;
    logic          dec_err_q;
    logic          len_err_q;

    logic [CW-1:0] len_nxt;
    logic [CW-1:0] bad_nxt;
    logic [IW-1:0] first_bad_nxt;
    logic          dec_err_nxt;
    logic          len_err_nxt;
    logic          hash_err_nxt;

    // Held result record.
    logic          r_pass;
    logic          r_dec_err;
    logic          r_hash_err;
    logic          r_len_err;
    logic [CW-1:0] r_bad_cnt;
    logic [IW-1:0] r_first_bad;
    logic [CW-1:0] r_len;
    logic [W-1:0]  r_hash;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt    = state;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) state_nxt = RES;
            end
            RES: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    assign accept   = (state == ACC) && bus.in_valid;
    assign res_done = (state == RES) && bus.res_ready;

    // Length never returns to zero inside a frame (it saturates), so a zero
    // length marks the first beat; that beat takes the key straight off the port.
    assign first_beat = (len_q == '0);
    assign beat_key   = first_beat ? bus.key : key_q;
    assign hash_in    = first_beat ? bus.key : hash_q;

    verify_step #(
        .W   (W),
        .ROT (ROT)
    ) u_step (
        .cipher   (bus.in_cipher),
        .plain    (bus.in_plain),
        .key      (beat_key),
        .hash_in  (hash_in),
        .dec_ok   (dec_ok),
        .hash_out (hash_out)
    );

    assign mismatch      = !dec_ok;
    assign in_range      = (len_q < LEN_MAX);
    assign len_nxt       = in_range ? len_q + CW'(1) : len_q;
    assign len_err_nxt   = len_err_q || !in_range;
    assign bad_nxt       = (mismatch && (bad_q != LEN_MAX)) ? bad_q + CW'(1) : bad_q;
    assign dec_err_nxt   = dec_err_q || mismatch;
    // Only the first mismatch, and only if it still has a representable index.
    assign first_bad_nxt = (mismatch && !dec_err_q && in_range) ? IW'(len_q) : first_bad_q;
    assign hash_err_nxt  = (hash_out != bus.ref_hash);

    // Accumulate accepted beats; the last beat hands off to the result record.
    always_ff @(posedge clk) begin
        if (rst || (accept && bus.in_last)) begin
            key_q       <= '0;
            hash_q      <= '0;
            len_q       <= '0;
            bad_q       <= '0;
            first_bad_q <= '0;
            dec_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else if (accept) begin
            key_q       <= beat_key;
            hash_q      <= hash_out;
            len_q       <= len_nxt;
            bad_q       <= bad_nxt;
            first_bad_q <= first_bad_nxt;
            dec_err_q   <= dec_err_nxt;
            len_err_q   <= len_err_nxt;
        end
    end

    // Capture the record on the last beat, hold it, clear it on consumption.
    always_ff @(posedge clk) begin
        if (rst || res_done) begin
            r_pass      <= 1'b0;
            r_dec_err   <= 1'b0;
            r_hash_err  <= 1'b0;
            r_len_err   <= 1'b0;
            r_bad_cnt   <= '0;
            r_first_bad <= '0;
            r_len       <= '0;
            r_hash      <= '0;
        end else if (accept && bus.in_last) begin
            r_pass      <= !dec_err_nxt && !hash_err_nxt && !len_err_nxt;
            r_dec_err   <= dec_err_nxt;
            r_hash_err  <= hash_err_nxt;
            r_len_err   <= len_err_nxt;
            r_bad_cnt   <= bad_nxt;
            r_first_bad <= first_bad_nxt;
            r_len       <= len_nxt;
            r_hash      <= hash_out;
        end
    end

    assign bus.res_pass      = r_pass;
    assign bus.res_dec_err   = r_dec_err;
    assign bus.res_hash_err  = r_hash_err;
    assign bus.res_len_err   = r_len_err;
    assign bus.res_bad_cnt   = r_bad_cnt;
    assign bus.res_first_bad = r_first_bad;
    assign bus.res_len       = r_len;
    assign bus.res_hash      = r_hash;

endmodule
